// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared types and constants for the branch predictor / redirect controller.
//   bp_state_t : redirect FSM states (RUN, RECOVER)
//   CNT_*      : 2-bit saturating counter encodings
//   BROP_*     : branch-op field constants (BrOp[4:3] class, BrOp[4] jump)
//   bp_entry_t : one prediction-table entry
//   pc_tag     : tag extraction from a PC for a given index width
//   cnt_step   : saturating counter step (never wraps)
// -----------------------------------------------------------------------------
package bp_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } bp_state_t;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  localparam int         BROP_W        = 5;
  localparam logic [1:0] BROP_CLS_NONE = 2'b00;
  localparam int         BROP_JUMP_BIT = 4;

  // Tag is held at its widest possible size (IDX_BITS = 0); the upper bits
  // are simply zero for larger tables, so one struct serves every width.
  localparam int TAG_W = 30;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       cnt;
    logic             uncond;
  } bp_entry_t;

  function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc,
                                              input int idx_bits);
    logic [31:0] shifted;
    shifted = pc >> (idx_bits + 2);
    return shifted[TAG_W-1:0];
  endfunction

  function automatic logic [1:0] cnt_step(input logic [1:0] cnt,
                                          input logic up);
    if (up) return (cnt == CNT_ST)  ? CNT_ST  : cnt + 2'd1;
    else    return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bp_table.sv
// -----------------------------------------------------------------------------
// bp_table
// Direct-mapped prediction table of 2^IDX_BITS entries.
//   clk, rst_n   : clock, async active-low reset (clears valid, cnt -> 01)
//   rd_idx       : combinational read port index (fetch lookup)
//   rd_entry     : entry at rd_idx, pre-update contents
//   upd_en       : resolve a branch this cycle (write port)
//   upd_pc       : PC of the resolved branch (selects index and tag)
//   upd_taken    : resolved outcome
//   upd_target   : resolved target
//   upd_jump     : unconditional jump (forces cnt = 11, sets uncond on alloc)
//   inv_en       : invalidate port enable
//   inv_idx      : entry to invalidate
// The write port performs the read-modify-write internally: hit entries get a
// counter step (and target refresh when taken); taken misses allocate.
// -----------------------------------------------------------------------------
module bp_table
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] rd_idx,
  output bp_entry_t           rd_entry,
  input  logic                upd_en,
  input  logic [31:0]         upd_pc,
  input  logic                upd_taken,
  input  logic [31:0]         upd_target,
  input  logic                upd_jump,
  input  logic                inv_en,
  input  logic [IDX_BITS-1:0] inv_idx
);

  localparam int DEPTH = 1 << IDX_BITS;

  localparam bp_entry_t RESET_ENTRY = '{
    valid: 1'b0, tag: '0, target: '0, cnt: CNT_WNT, uncond: 1'b0
  };

  bp_entry_t           mem [DEPTH];
  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_W-1:0]    upd_tag;
  bp_entry_t           cur_entry;
  bp_entry_t           nxt_entry;
  logic                upd_hit;
  logic                do_write;

  assign rd_entry = mem[rd_idx];
  assign upd_idx  = upd_pc[IDX_BITS+1:2];
  assign upd_tag  = pc_tag(upd_pc, IDX_BITS);

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    cur_entry = mem[upd_idx];
    upd_hit   = cur_entry.valid && (cur_entry.tag == upd_tag);
    nxt_entry = cur_entry;
    do_write  = 1'b0;
    if (upd_en) begin
      if (upd_hit) begin
        do_write      = 1'b1;
        nxt_entry.cnt = upd_jump ? CNT_ST : cnt_step(cur_entry.cnt, upd_taken);
        if (upd_taken) nxt_entry.target = upd_target;
      end else if (upd_taken) begin
        // Taken miss overwrites whatever occupied the slot.
        do_write  = 1'b1;
        nxt_entry = '{valid: 1'b1, tag: upd_tag, target: upd_target,
                      cnt: upd_jump ? CNT_ST : CNT_WT, uncond: upd_jump};
      end
    end
  end

  // NOTE: the whole array is reset, not just a valid vector: a reset must make
  // every entry predict not-taken and restart its counter at weakly-not-taken.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample their inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_ENTRY;
    end else begin
      if (do_write) mem[upd_idx] <= nxt_entry;
      if (inv_en)   mem[inv_idx].valid <= 1'b0;
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// branch_redirect_ctrl
// Branch prediction and PC-redirect controller for the 5-stage pipeline.
//   PcIf / PredTaken_if / PredTarget_if   : combinational fetch lookup
//   Valid_ex, Stall_ex, BrOp_ex,
//   NextPcSrc_ex, PcEx, TargetEx,
//   PredTaken_ex, PredTarget_ex           : resolved branch from EX
//   Redirect / RedirectPc                 : same-cycle PC correction
//   FlushIfId / FlushIdEx                 : squash younger slots (= Redirect)
//   BranchCnt / MispredCnt                : saturating statistics
// After a redirect the FSM spends one cycle in RECOVER, where the squashed EX
// slot is ignored: no update, no redirect, no counting.
// -----------------------------------------------------------------------------
module branch_redirect_ctrl
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       PcIf,
  output logic              PredTaken_if,
  output logic [31:0]       PredTarget_if,
  input  logic              Valid_ex,
  input  logic              Stall_ex,
  input  logic [BROP_W-1:0] BrOp_ex,
  input  logic              NextPcSrc_ex,
  input  logic [31:0]       PcEx,
  input  logic [31:0]       TargetEx,
  input  logic              PredTaken_ex,
  input  logic [31:0]       PredTarget_ex,
  output logic              Redirect,
  output logic [31:0]       RedirectPc,
  output logic              FlushIfId,
  output logic              FlushIdEx,
  output logic [CNT_W-1:0]  BranchCnt,
  output logic [CNT_W-1:0]  MispredCnt
);

  bp_state_t state;
  bp_entry_t fetch_entry;
  logic      fetch_hit;
  logic      resolve;
  logic      is_br;
  logic      taken;
  logic      mispred;
  logic      alias_inv;
  logic      brop_unused;

  // The function bits of the op only matter to the branch unit itself.
  assign brop_unused = ^BrOp_ex[2:0];

  // Fetch lookup: pre-update contents, no bypass from the EX write.
  assign fetch_hit     = fetch_entry.valid &&
                         (fetch_entry.tag == pc_tag(PcIf, IDX_BITS));
  assign PredTaken_if  = fetch_hit && (fetch_entry.uncond || fetch_entry.cnt[1]);
  assign PredTarget_if = PredTaken_if ? fetch_entry.target : 32'd0;

  // Resolution in EX.
  assign resolve    = (state == RUN) && Valid_ex && !Stall_ex;
  assign is_br      = (BrOp_ex[4:3] != BROP_CLS_NONE);
  assign taken      = is_br && NextPcSrc_ex;
  assign mispred    = (taken != PredTaken_ex) ||
                      (taken && (PredTarget_ex != TargetEx));
  // A non-branch that fetch predicted taken hit an aliased entry: drop it.
  assign alias_inv  = resolve && !is_br && PredTaken_ex;

  assign Redirect   = resolve && mispred;
  assign RedirectPc = !Redirect ? 32'd0 : (taken ? TargetEx : PcEx + 32'd4);
  assign FlushIfId  = Redirect;
  assign FlushIdEx  = Redirect;

  bp_table #(.IDX_BITS(IDX_BITS)) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx     (PcIf[IDX_BITS+1:2]),
    .rd_entry   (fetch_entry),
    .upd_en     (resolve && is_br),
    .upd_pc     (PcEx),
    .upd_taken  (taken),
    .upd_target (TargetEx),
    .upd_jump   (BrOp_ex[BROP_JUMP_BIT]),
    .inv_en     (alias_inv),
    .inv_idx    (PcEx[IDX_BITS+1:2])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (Redirect) state <= RECOVER;
        RECOVER: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BranchCnt  <= '0;
      MispredCnt <= '0;
    end else if (resolve) begin
      if (is_br   && (BranchCnt  != '1)) BranchCnt  <= BranchCnt  + 1'b1;
      if (mispred && (MispredCnt != '1)) MispredCnt <= MispredCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_redirect_ctrl
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural model of the prediction table (owner PC, counter, target,
// unconditional flag per slot) and the one-cycle recovery window.
// -----------------------------------------------------------------------------
module tb_branch_redirect_ctrl;

  localparam int IDX_BITS = 4;
  localparam int CNT_W    = 16;
  localparam int ENTRIES  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       PcIf;
  logic              PredTaken_if;
  logic [31:0]       PredTarget_if;
  logic              Valid_ex;
  logic              Stall_ex;
  logic [4:0]        BrOp_ex;
  logic              NextPcSrc_ex;
  logic [31:0]       PcEx;
  logic [31:0]       TargetEx;
  logic              PredTaken_ex;
  logic [31:0]       PredTarget_ex;
  logic              Redirect;
  logic [31:0]       RedirectPc;
  logic              FlushIfId;
  logic              FlushIdEx;
  logic [CNT_W-1:0]  BranchCnt;
  logic [CNT_W-1:0]  MispredCnt;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.IDX_BITS(IDX_BITS), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PcIf          (PcIf),
    .PredTaken_if  (PredTaken_if),
    .PredTarget_if (PredTarget_if),
    .Valid_ex      (Valid_ex),
    .Stall_ex      (Stall_ex),
    .BrOp_ex       (BrOp_ex),
    .NextPcSrc_ex  (NextPcSrc_ex),
    .PcEx          (PcEx),
    .TargetEx      (TargetEx),
    .PredTaken_ex  (PredTaken_ex),
    .PredTarget_ex (PredTarget_ex),
    .Redirect      (Redirect),
    .RedirectPc    (RedirectPc),
    .FlushIfId     (FlushIfId),
    .FlushIdEx     (FlushIdEx),
    .BranchCnt     (BranchCnt),
    .MispredCnt    (MispredCnt)
  );

  // ---------------- reference model ----------------
  bit          m_valid [ENTRIES];
  logic [31:0] m_owner [ENTRIES];
  int          m_cnt   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  bit          m_unc   [ENTRIES];
  bit          m_recover;
  int          m_br;
  int          m_mis;

  bit          e_resolve, e_isbr, e_taken, e_misp, e_redirect;
  logic [31:0] e_rpc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] pc_pool  [6] = '{32'h100, 32'h104, 32'h140, 32'h200, 32'h244, 32'h1000_0100};
  logic [31:0] tgt_pool [5] = '{32'h80, 32'h300, 32'h340, 32'h104, 32'h1000};

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int i = idx_of(pc);
    return m_valid[i] && ((m_owner[i] >> 6) == (pc >> 6));
  endfunction

  function automatic void model_pred(input logic [31:0] pc, output bit tk,
                                     output logic [31:0] tg);
    int i = idx_of(pc);
    tk = m_hit(pc) && (m_unc[i] || m_cnt[i] >= 2);
    tg = tk ? m_tgt[i] : 32'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_owner[i] = 0; m_cnt[i] = 1; m_tgt[i] = 0; m_unc[i] = 0;
    end
    m_recover = 0; m_br = 0; m_mis = 0;
  endtask

  task automatic compute_exp();
    e_resolve  = !m_recover && Valid_ex && !Stall_ex;
    e_isbr     = (BrOp_ex >= 5'd8);
    e_taken    = e_isbr && NextPcSrc_ex;
    e_misp     = (e_taken != PredTaken_ex) || (e_taken && PredTarget_ex != TargetEx);
    e_redirect = e_resolve && e_misp;
    e_rpc      = !e_redirect ? 32'd0 : (e_taken ? TargetEx : PcEx + 32'd4);
  endtask

  task automatic model_update();
    int i = idx_of(PcEx);
    bit jump = (BrOp_ex >= 5'd16);
    if (e_resolve) begin
      if (e_isbr) begin
        m_br = (m_br < 65535) ? m_br + 1 : m_br;
        if (m_hit(PcEx)) begin
          if (jump)         m_cnt[i] = 3;
          else if (e_taken) m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
          else              m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
          if (e_taken) m_tgt[i] = TargetEx;
        end else if (e_taken) begin
          m_valid[i] = 1; m_owner[i] = PcEx; m_tgt[i] = TargetEx;
          m_cnt[i] = jump ? 3 : 2; m_unc[i] = jump;
        end
      end else if (PredTaken_ex) begin
        m_valid[i] = 0;
      end
      if (e_misp) m_mis = (m_mis < 65535) ? m_mis + 1 : m_mis;
    end
    m_recover = e_redirect;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Sample at the falling edge, compare every output against the model.
  task automatic settle();
    bit          p_tk;
    logic [31:0] p_tg;
    @(negedge clk);
    compute_exp();
    model_pred(PcIf, p_tk, p_tg);
    check("pred_taken",  {31'd0, PredTaken_if}, {31'd0, p_tk});
    check("pred_target", PredTarget_if, p_tg);
    check("redirect",    {31'd0, Redirect},  {31'd0, e_redirect});
    check("redirect_pc", RedirectPc, e_rpc);
    check("flush_ifid",  {31'd0, FlushIfId}, {31'd0, e_redirect});
    check("flush_idex",  {31'd0, FlushIdEx}, {31'd0, e_redirect});
    check("branch_cnt",  {16'd0, BranchCnt},  32'(m_br));
    check("mispred_cnt", {16'd0, MispredCnt}, 32'(m_mis));
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic v, input logic st, input logic [4:0] op,
                       input logic nps, input logic [31:0] pc, input logic [31:0] tg,
                       input logic pt, input logic [31:0] ptg);
    Valid_ex = v; Stall_ex = st; BrOp_ex = op; NextPcSrc_ex = nps;
    PcEx = pc; TargetEx = tg; PredTaken_ex = pt; PredTarget_ex = ptg;
  endtask

  localparam logic [4:0] OP_NONE = 5'b00000;
  localparam logic [4:0] OP_BEQ  = 5'b01000;
  localparam logic [4:0] OP_JALR = 5'b10001;

  initial begin
    bit          p_tk;
    logic [31:0] p_tg;
    logic [4:0]  op;
    logic [31:0] pc;

    rst_n = 1'b0;
    PcIf  = 32'h100;
    drive(0, 0, OP_NONE, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state and first fetch.
    settle();
    check("reset_pred_taken", {31'd0, PredTaken_if}, 32'd0);
    check("reset_redirect",   {31'd0, Redirect}, 32'd0);
    check("reset_branch_cnt", {16'd0, BranchCnt}, 32'd0);
    advance();

    // BEQ at 0x100 taken to 0x80, predicted not-taken.
    drive(1, 0, OP_BEQ, 1, 32'h100, 32'h80, 0, 0);
    settle();
    check("beq_redirect",    {31'd0, Redirect}, 32'd1);
    check("beq_redirect_pc", RedirectPc, 32'h80);
    check("beq_flushes",     {30'd0, FlushIfId, FlushIdEx}, 32'd3);
    advance();

    // RECOVER: same mispredicting slot must be ignored.
    settle();
    check("recover_no_redirect", {31'd0, Redirect}, 32'd0);
    check("recover_pred_taken",  {31'd0, PredTaken_if}, 32'd1);
    check("recover_pred_target", PredTarget_if, 32'h80);
    check("recover_mispred_cnt", {16'd0, MispredCnt}, 32'd1);
    advance();

    // Not-taken twice: 10 -> 01 (mispredict to 0x104) -> 00 (correct).
    drive(1, 0, OP_BEQ, 0, 32'h100, 32'h80, 1, 32'h80);
    settle();
    check("nt1_redirect_pc", RedirectPc, 32'h104);
    advance();
    drive(0, 0, OP_NONE, 0, 0, 0, 0, 0);
    settle();
    advance();
    check("nt1_pred_after", {31'd0, PredTaken_if}, 32'd0);
    drive(1, 0, OP_BEQ, 0, 32'h100, 32'h80, 0, 0);
    settle();
    check("nt2_no_redirect", {31'd0, Redirect}, 32'd0);
    advance();

    // JALR at 0x200 predicted 0x300, actual 0x340.
    drive(1, 0, OP_JALR, 1, 32'h200, 32'h340, 1, 32'h300);
    settle();
    check("jalr_redirect_pc", RedirectPc, 32'h340);
    advance();
    drive(0, 0, OP_NONE, 0, 0, 0, 0, 0);
    PcIf = 32'h200;
    settle();
    check("jalr_new_target", PredTarget_if, 32'h340);
    advance();

    // Mispredicting branch held by a 3-cycle stall.
    drive(1, 1, OP_BEQ, 1, 32'h180, 32'h80, 0, 0);
    for (int c = 0; c < 3; c++) begin
      settle();
      check("stall_no_redirect", {31'd0, Redirect}, 32'd0);
      check("stall_branch_cnt",  {16'd0, BranchCnt}, 32'd4);
      advance();
    end
    Stall_ex = 1'b0;
    settle();
    check("unstall_redirect", {31'd0, Redirect}, 32'd1);
    advance();
    check("unstall_branch_cnt",  {16'd0, BranchCnt}, 32'd5);
    check("unstall_mispred_cnt", {16'd0, MispredCnt}, 32'd4);

    // Asynchronous reset in the middle of RECOVER.
    Valid_ex = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    PcIf = 32'h100;
    #1 check("async_rst_pred_100", {31'd0, PredTaken_if}, 32'd0);
    PcIf = 32'h200;
    #1 check("async_rst_pred_200", {31'd0, PredTaken_if}, 32'd0);
    check("async_rst_branch_cnt",  {16'd0, BranchCnt}, 32'd0);
    check("async_rst_mispred_cnt", {16'd0, MispredCnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // State is RUN right away: a mispredict redirects immediately.
    drive(1, 0, OP_BEQ, 1, 32'h104, 32'h300, 0, 0);
    settle();
    check("post_rst_redirect", {31'd0, Redirect}, 32'd1);
    advance();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      PcIf = pc_pool[$urandom_range(0, 5)];
      pc   = pc_pool[$urandom_range(0, 5)];
      case ($urandom_range(0, 3))
        0:       op = {2'b00, 3'($urandom_range(0, 7))};
        3:       op = {2'b10, 3'($urandom_range(0, 7))};
        default: op = {2'b01, 3'($urandom_range(0, 7))};
      endcase
      model_pred(pc, p_tk, p_tg);
      if ($urandom_range(0, 3) == 0) begin
        p_tk = 1'($urandom_range(0, 1));
        p_tg = p_tk ? tgt_pool[$urandom_range(0, 4)] : 32'd0;
      end
      drive(($urandom_range(0, 9) != 0),
            m_recover ? 1'b0 : ($urandom_range(0, 4) == 0),
            op,
            op[4] ? 1'b1 : 1'($urandom_range(0, 1)),
            pc, tgt_pool[$urandom_range(0, 4)], p_tk, p_tg);
      settle();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Branch prediction and PC-redirect controller for the 5-stage RISC-V pipeline. It predicts taken/target at fetch from a direct-mapped table of 2-bit saturating counters plus branch targets. It takes the branch-unit outcome (`NextPcSrc`) and `BrOp_ex` from EX, updates the table, and on a mispredict drives the PC redirect and the IF/ID and ID/EX flushes. A one-cycle recovery state keeps the squashed slot from updating the table.

## Interface
- `IDX_BITS`, 4: table index width; 2^IDX_BITS entries, indexed by PC[IDX_BITS+1:2].
- `CNT_W`, 16: width of the statistics counters.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `PcIf`  in  32  fetch PC.
- `PredTaken_if`  out  1  fetch prediction (combinational lookup).
- `PredTarget_if`  out  32  predicted target; 0 when `PredTaken_if`=0.
- `Valid_ex`  in  1  EX slot holds a real instruction.
- `Stall_ex`  in  1  EX held this cycle; no update, no redirect.
- `BrOp_ex`  in  5  branch op; same encoding as the BU (00xxx none, 01xxx conditional, 1xxxx jump).
- `NextPcSrc_ex`  in  1  BU outcome, 1 = taken.
- `PcEx`, `TargetEx`  in  32 each  EX PC and computed target.
- `PredTaken_ex`, `PredTarget_ex`  in  1/32  fetch prediction piped to EX.
- `Redirect`  out  1  load PC with `RedirectPc` this cycle.
- `RedirectPc`  out  32  corrected PC.
- `FlushIfId`, `FlushIdEx`  out  1 each  squash IF/ID and ID/EX, equal to `Redirect`.
- `BranchCnt`, `MispredCnt`  out  CNT_W each  resolved branches and mispredicts, saturating.

## Operation
- Entry fields: `valid`, `tag` = PC[31:IDX_BITS+2], `target`[31:0], `cnt`[1:0], `uncond`.
- Lookup: hit = valid && tag match. `PredTaken_if` = hit && (uncond || cnt[1]).
- Resolve condition: state RUN && `Valid_ex` && !`Stall_ex`.
- `isBr` = `BrOp_ex`[4:3] != 00.
- Taken = `NextPcSrc_ex` when `isBr`, else 0.
- Mispredict when any of these holds:
  - Taken != `PredTaken_ex`.
  - Taken && `PredTarget_ex` != `TargetEx`.
- `RedirectPc` = Taken ? `TargetEx` : `PcEx`+4 (mod 2^32).
- `Redirect` = resolve && mispredict. Combinational, same cycle.
- Table update on resolve with `isBr`:
  - Hit entry: cnt saturating +1 if taken, −1 if not. Never wraps: 11+1 = 11, 00−1 = 00.
  - Hit entry, taken: target is rewritten with `TargetEx`.
  - Miss, taken: allocate (overwrite) with cnt = 10, target = `TargetEx`, `uncond` = `BrOp_ex`[4].
  - Miss, not taken: no allocation.
  - Jumps force cnt = 11.
- Aliased hit on a non-branch (`isBr`=0, `PredTaken_ex`=1): mispredict to `PcEx`+4, and the entry at PcEx index is invalidated.
- Statistics, on resolve: `BranchCnt` +1 when `isBr`. `MispredCnt` +1 when mispredict. Both saturate at all-ones.
- FSM states:
  - RUN → RECOVER when `Redirect`=1.
  - RECOVER → RUN unconditionally after one cycle. In RECOVER there are no updates, no redirect, and no counting; the slot is a flushed bubble.
- Reset values:
  - State RUN, all `valid`=0, all cnt=01, statistics counters 0.
  - Outputs: `Redirect`, flushes, `PredTaken_if`=0; `RedirectPc`=0 when not redirecting.

## Timing
- Lookup and redirect are zero-latency combinational outputs. Table, FSM and counters update on the rising edge.
- Lookup and update hitting the same index in one cycle: lookup returns pre-update contents (no bypass).
- Writes take effect at the next edge.
- `Stall_ex`=1 holds everything: no double update of a stalled branch, and the FSM stays put.
- Reset asserted mid-operation clears the table and state immediately, asynchronously.
- First fetch after reset release predicts not-taken.

## Structure
- Package `bp_pkg` holds:
  - `bp_state_t` {RUN, RECOVER}.
  - Counter constants `CNT_SNT`=00, `CNT_WNT`=01, `CNT_WT`=10, `CNT_ST`=11.
  - `BrOp` field constants.
  - `bp_entry_t` struct.
- Sub-module `bp_table`: storage array with one combinational read port, one write port and an invalidate port, async reset clearing `valid`/cnt.
- Top level holds the mispredict logic, FSM and statistics counters.

## Test plan
- Reset, then `PcIf`=0x100 → `PredTaken_if`=0. Statistics read 0, `Redirect`=0.
- BEQ at 0x100, taken to 0x80, `PredTaken_ex`=0 → `Redirect`=1, `RedirectPc`=0x80, both flushes=1. Next cycle RECOVER ignores `Valid_ex`. Lookup of 0x100 then predicts taken to 0x80, `MispredCnt`=1.
- Same BEQ not-taken twice → cnt 10→01→00. The first not-taken redirects to 0x104; the second is predicted not-taken, no redirect.
- JALR at 0x200, predicted 0x300, actual `TargetEx`=0x340 → redirect to 0x340, entry target updated to 0x340.
- `Stall_ex`=1 with a mispredicting branch for 3 cycles → no redirect and no counter change until the stall drops; then exactly one redirect and +1 on each count.
- `rst_n` low mid-RECOVER → state RUN, `PredTaken_if`=0 for all prior PCs, counters 0.
